// File: rtl/pulse_mon_pkg.sv
// Shared definitions for the pulse burst monitor: FSM state encoding and a
// saturating increment used by every burst counter.
package pulse_mon_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StHigh   = 2'd1,
      StLow    = 2'd2,
      StReport = 2'd3
   } state_e;

   // Counters are zero-extended to 32 bits by the caller and truncated back.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
      return (val >= max_val) ? max_val : val + 32'd1;
   endfunction

endpackage

// File: rtl/pulse_burst_monitor_if.sv
// Burst report channel: valid/ready handshake plus the per-burst fields.
interface pulse_burst_monitor_if #(
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned TIME_W = 8
);
   logic              valid;
   logic              ready;
   logic [CNT_W-1:0]  count;
   logic [TIME_W-1:0] len;
   logic [TIME_W-1:0] max_high;
   logic              overflow;

   modport master (
      output valid,
      output count,
      output len,
      output max_high,
      output overflow,
      input  ready
   );

   modport slave (
      input  valid,
      input  count,
      input  len,
      input  max_high,
      input  overflow,
      output ready
   );
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous pulse input, followed by a
// delay register that yields single-cycle rise/fall strobes.
module sync_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_i,
   output logic sig_s_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic sig_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         sig_q  <= 1'b0;
      end else begin
         meta_q <= sig_i;
         sync_q <= meta_q;
         sig_q  <= sync_q;
      end
   end

   assign sig_s_o = sync_q;
   assign rise_o  = sync_q & ~sig_q;
   assign fall_o  = ~sync_q & sig_q;

endmodule

// File: rtl/pulse_burst_monitor.sv
// Groups synchronized input pulses into bursts and reports pulse count, burst
// length and widest high phase of each burst over a valid/ready channel.
module pulse_burst_monitor
   import pulse_mon_pkg::*;
#(
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned TIME_W     = 8,
   parameter int unsigned IDLE_LIMIT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sig_in_i,
   input  logic                  clear_i,
   output logic                  busy_o,
   pulse_burst_monitor_if.master burst_io
);

   localparam logic [CNT_W-1:0]  CntMax  = '1;
   localparam logic [TIME_W-1:0] TimeMax = '1;
   localparam logic [TIME_W-1:0] IdleLim = TIME_W'(IDLE_LIMIT);

   logic sig_s;
   logic rise;
   logic fall;

   sync_edge_det u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .sig_i   (sig_in_i),
      .sig_s_o (sig_s),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   state_e            state_q;
   logic [CNT_W-1:0]  count_q;
   logic [TIME_W-1:0] len_q;
   logic [TIME_W-1:0] hi_q;
   logic [TIME_W-1:0] max_high_q;
   logic [TIME_W-1:0] len_fall_q;
   logic [TIME_W-1:0] idle_q;
   logic              ovf_q;
   logic              busy_q;
   logic              valid_q;
   logic [CNT_W-1:0]  rep_count_q;
   logic [TIME_W-1:0] rep_len_q;
   logic [TIME_W-1:0] rep_max_q;
   logic              rep_ovf_q;

   logic [CNT_W-1:0]  count_inc;
   logic [TIME_W-1:0] len_inc;
   logic [TIME_W-1:0] hi_inc;
   logic              count_at_max;
   logic              len_at_max;
   logic              hi_at_max;

   assign count_inc    = CNT_W'(sat_inc(32'(count_q), 32'(CntMax)));
   assign len_inc      = TIME_W'(sat_inc(32'(len_q), 32'(TimeMax)));
   assign hi_inc       = TIME_W'(sat_inc(32'(hi_q), 32'(TimeMax)));
   assign count_at_max = (count_q == CntMax);
   assign len_at_max   = (len_q == TimeMax);
   assign hi_at_max    = (hi_q == TimeMax);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         count_q     <= '0;
         len_q       <= '0;
         hi_q        <= '0;
         max_high_q  <= '0;
         len_fall_q  <= '0;
         idle_q      <= '0;
         ovf_q       <= 1'b0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         rep_count_q <= '0;
         rep_len_q   <= '0;
         rep_max_q   <= '0;
         rep_ovf_q   <= 1'b0;
      end else if (clear_i) begin
         state_q     <= StIdle;
         count_q     <= '0;
         len_q       <= '0;
         hi_q        <= '0;
         max_high_q  <= '0;
         len_fall_q  <= '0;
         idle_q      <= '0;
         ovf_q       <= 1'b0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         rep_count_q <= '0;
         rep_len_q   <= '0;
         rep_max_q   <= '0;
         rep_ovf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (rise) begin
                  state_q    <= StHigh;
                  busy_q     <= 1'b1;
                  count_q    <= CNT_W'(1);
                  len_q      <= TIME_W'(1);
                  hi_q       <= TIME_W'(1);
                  max_high_q <= '0;
                  ovf_q      <= 1'b0;
               end
            end
            StHigh: begin
               len_q <= len_inc;
               if (len_at_max) ovf_q <= 1'b1;
               // hi only tracks cycles that are actually high, so the fall cycle is excluded
               if (sig_s) begin
                  hi_q <= hi_inc;
                  if (hi_at_max) ovf_q <= 1'b1;
               end
               if (fall) begin
                  state_q    <= StLow;
                  max_high_q <= (hi_q > max_high_q) ? hi_q : max_high_q;
                  len_fall_q <= len_q;
                  idle_q     <= TIME_W'(1);
               end
            end
            StLow: begin
               len_q <= len_inc;
               if (len_at_max) ovf_q <= 1'b1;
               // The burst is already over once IDLE_LIMIT lows are seen; a coincident rise is lost.
               if (idle_q == IdleLim) begin
                  state_q     <= StReport;
                  valid_q     <= 1'b1;
                  rep_count_q <= count_q;
                  rep_len_q   <= len_fall_q;
                  rep_max_q   <= max_high_q;
                  rep_ovf_q   <= ovf_q | len_at_max;
               end else begin
                  idle_q <= idle_q + 1'b1;
                  if (rise) begin
                     state_q <= StHigh;
                     hi_q    <= TIME_W'(1);
                     count_q <= count_inc;
                     if (count_at_max) ovf_q <= 1'b1;
                  end
               end
            end
            StReport: begin
               if (burst_io.ready) begin
                  state_q     <= StIdle;
                  busy_q      <= 1'b0;
                  valid_q     <= 1'b0;
                  rep_count_q <= '0;
                  rep_len_q   <= '0;
                  rep_max_q   <= '0;
                  rep_ovf_q   <= 1'b0;
               end
            end
         endcase
      end
   end

   assign busy_o            = busy_q;
   assign burst_io.valid    = valid_q;
   assign burst_io.count    = rep_count_q;
   assign burst_io.len      = rep_len_q;
   assign burst_io.max_high = rep_max_q;
   assign burst_io.overflow = rep_ovf_q;

endmodule

// File: tb/tb_pulse_burst_monitor.sv
// Directed bench for pulse_burst_monitor: a default instance and a CNT_W=4
// instance share all inputs so counter saturation can be observed side by side.
module tb_pulse_burst_monitor;

   logic clk = 1'b0;
   logic rst_n;
   logic sig_in;
   logic clear;
   logic ready;
   logic busy8;
   logic busy4;

   int n_cmp = 0;
   int n_err = 0;

   pulse_burst_monitor_if #(.CNT_W(8), .TIME_W(8)) bus8 ();
   pulse_burst_monitor_if #(.CNT_W(4), .TIME_W(8)) bus4 ();

   assign bus8.ready = ready;
   assign bus4.ready = ready;

   pulse_burst_monitor #(.CNT_W(8), .TIME_W(8), .IDLE_LIMIT(16)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sig_in_i (sig_in),
      .clear_i  (clear),
      .busy_o   (busy8),
      .burst_io (bus8)
   );

   pulse_burst_monitor #(.CNT_W(4), .TIME_W(8), .IDLE_LIMIT(16)) u_dut4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .sig_in_i (sig_in),
      .clear_i  (clear),
      .busy_o   (busy4),
      .burst_io (bus4)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse(input int h, input int l);
      sig_in = 1'b1;
      repeat (h) tick();
      sig_in = 1'b0;
      repeat (l) tick();
   endtask

   task automatic wait_valid(input string tag, input int limit);
      int n = 0;
      while (bus8.valid !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus8.valid), 32'd1);
   endtask

   task automatic check_report(input string tag, input int c, input int l, input int m,
                               input int o);
      chk({tag, "_count"}, 32'(bus8.count), 32'(c));
      chk({tag, "_len"}, 32'(bus8.len), 32'(l));
      chk({tag, "_max"}, 32'(bus8.max_high), 32'(m));
      chk({tag, "_ovf"}, 32'(bus8.overflow), 32'(o));
   endtask

   task automatic accept(input string tag);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk({tag, "_acc_valid"}, 32'(bus8.valid), 32'd0);
      chk({tag, "_acc_busy"}, 32'(busy8), 32'd0);
   endtask

   task automatic expect_quiet(input string tag, input int n);
      int seen = 0;
      repeat (n) begin
         tick();
         if (bus8.valid !== 1'b0 || busy8 !== 1'b0) seen++;
      end
      chk(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unstable;
      rst_n  = 1'b0;
      sig_in = 1'b0;
      clear  = 1'b0;
      ready  = 1'b0;
      repeat (3) tick();
      chk("rst_valid", 32'(bus8.valid), 32'd0);
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_count", 32'(bus8.count), 32'd0);
      chk("rst_len", 32'(bus8.len), 32'd0);
      rst_n = 1'b1;
      repeat (3) tick();

      // Three 2-high/2-low pulses, report held until ready.
      repeat (3) pulse(2, 2);
      chk("t1_busy", 32'(busy8), 32'd1);
      wait_valid("t1_valid", 60);
      check_report("t1", 3, 10, 2, 0);
      repeat (5) tick();
      chk("t1_hold_valid", 32'(bus8.valid), 32'd1);
      chk("t1_hold_count", 32'(bus8.count), 32'd3);
      accept("t1");

      // Widths 1, 5, 3 with 3-cycle gaps.
      pulse(1, 3);
      pulse(5, 3);
      pulse(3, 0);
      wait_valid("t2_valid", 60);
      check_report("t2", 3, 15, 5, 0);
      accept("t2");

      // Gap of 15 lows keeps both pulses in one burst.
      pulse(2, 15);
      pulse(2, 0);
      wait_valid("t3_valid", 60);
      check_report("t3", 2, 19, 2, 0);
      accept("t3");

      // Gap of 16 lows closes the first burst; the next rise lands on the timeout.
      pulse(2, 16);
      pulse(2, 3);
      wait_valid("t4_valid", 60);
      check_report("t4", 1, 2, 2, 0);
      unstable = 0;
      for (int i = 0; i < 10; i++) begin
         pulse(2, 3);
         if (bus8.valid !== 1'b1 || bus8.count !== 8'd1 || bus8.len !== 8'd2 ||
             bus8.max_high !== 8'd2) unstable++;
      end
      chk("t4_hold_50", 32'(unstable), 32'd0);
      check_report("t4_late", 1, 2, 2, 0);
      accept("t4");
      expect_quiet("t4_no_second", 25);

      // Twenty pulses: the 4-bit counter saturates, the 8-bit one does not.
      repeat (20) pulse(2, 2);
      wait_valid("t5_valid", 60);
      check_report("t5", 20, 78, 2, 0);
      chk("t5_c4_count", 32'(bus4.count), 32'd15);
      chk("t5_c4_ovf", 32'(bus4.overflow), 32'd1);
      chk("t5_c4_len", 32'(bus4.len), 32'd78);
      accept("t5");
      repeat (3) pulse(2, 2);
      wait_valid("t6_valid", 60);
      chk("t6_c4_count", 32'(bus4.count), 32'd3);
      chk("t6_c4_ovf", 32'(bus4.overflow), 32'd0);
      accept("t6");

      // Clear while in LOW.
      pulse(2, 3);
      chk("t7_busy", 32'(busy8), 32'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t7_valid", 32'(bus8.valid), 32'd0);
      chk("t7_busy_clr", 32'(busy8), 32'd0);
      expect_quiet("t7_no_report", 25);

      // Clear while in REPORT.
      pulse(2, 0);
      wait_valid("t8_valid", 60);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t8_valid_clr", 32'(bus8.valid), 32'd0);
      chk("t8_busy_clr", 32'(busy8), 32'd0);
      chk("t8_count_clr", 32'(bus8.count), 32'd0);
      chk("t8_len_clr", 32'(bus8.len), 32'd0);
      expect_quiet("t8_no_report", 10);

      // Asynchronous reset in HIGH.
      sig_in = 1'b1;
      repeat (3) tick();
      chk("t9_busy", 32'(busy8), 32'd1);
      rst_n  = 1'b0;
      sig_in = 1'b0;
      #1;
      chk("t9_busy_rst", 32'(busy8), 32'd0);
      chk("t9_valid_rst", 32'(bus8.valid), 32'd0);
      tick();
      rst_n = 1'b1;
      expect_quiet("t9_no_report", 25);

      // Asynchronous reset in REPORT.
      pulse(2, 0);
      wait_valid("t10_valid", 60);
      rst_n = 1'b0;
      #1;
      chk("t10_valid_rst", 32'(bus8.valid), 32'd0);
      chk("t10_count_rst", 32'(bus8.count), 32'd0);
      chk("t10_busy_rst", 32'(busy8), 32'd0);
      tick();
      rst_n = 1'b1;
      expect_quiet("t10_no_report", 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
